// File: rtl/acc_cpu_core_pkg.sv
// cpu_pkg: opcode and FSM state definitions shared by the accumulator CPU core and its ALU.
package cpu_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_CLR = 4'hD;
  localparam logic [3:0] OP_RSV = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MUL, ST_HALT} state_t;
  function automatic logic writes_acc(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_SHL, OP_SHR, OP_CLR};
  endfunction
endpackage

// File: rtl/acc_cpu_core_if.sv
// acc_cpu_core_if: instruction-fetch bus between the core (master) and instruction memory (slave).
//   imem_req/imem_addr from core; imem_valid/imem_data from memory.
interface acc_cpu_core_if #(parameter int ADDR_W = 8, parameter int OPND_W = 4);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [3+OPND_W:0] imem_data;
  modport master(output imem_req, imem_addr, input imem_valid, imem_data);
  modport slave(input imem_req, imem_addr, output imem_valid, imem_data);
endinterface

// File: rtl/acc_cpu_core_alu.sv
// acc_alu: combinational accumulator ALU.
//   op/acc/opnd/c_in in; result, c_out (c_in passed through when op leaves carry alone), z_out out.
module acc_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] opnd,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              c_out,
  output logic              z_out
);
  always_comb begin
    {c_out, result} = {c_in, acc};
    case (op)
      OP_ADD: {c_out, result} = {1'b0, acc} + {1'b0, opnd};
      OP_SUB: {c_out, result} = {acc < opnd, acc - opnd};
      OP_AND: result = acc & opnd;
      OP_OR:  result = acc | opnd;
      OP_XOR: result = acc ^ opnd;
      OP_LDI: result = opnd;
      OP_SHL: {c_out, result} = {acc, 1'b0};
      OP_SHR: {result, c_out} = {1'b0, acc};
      OP_CLR: {c_out, result} = '0;
      default: ;
    endcase
  end
  assign z_out = result == '0;
endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: parametrised accumulator CPU with Z/C flags, branches, fetch handshake and HALT.
//   clk, reset_n (async active-low), run_en (gates new fetches), imem (fetch bus master),
//   acc_out/pc_out/flag_z/flag_c/halted debug outputs.
//   Define CPU_MUL_EN to make opcode C a shift-add multiply; otherwise opcode C is a NOP.
module acc_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int OPND_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run_en,
  acc_cpu_core_if.master       imem,
  output logic [DATA_W-1:0]    acc_out,
  output logic [ADDR_W-1:0]    pc_out,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 halted
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc, w_pc_inc, w_pc_next, w_tgt;
  logic [DATA_W-1:0] r_acc, w_res, w_opnd;
  logic [3+OPND_W:0] r_ir;
  logic [3:0]        w_op;
  logic              r_z, r_c, r_pend, w_c, w_z, w_req, w_fire, w_jump;
  assign w_op      = r_ir[3+OPND_W -: 4];
  assign w_opnd    = DATA_W'(r_ir[OPND_W-1:0]);
  assign w_tgt     = ADDR_W'(r_ir[OPND_W-1:0]);
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_jump    = w_op == OP_JMP || (w_op == OP_JZ && r_z) || (w_op == OP_JC && r_c);
  assign w_pc_next = w_jump ? w_tgt : w_op == OP_HLT ? r_pc : w_pc_inc;
  // Gated by reset_n so the request drops the instant reset asserts; a pending
  // request keeps going after run_en falls until memory answers it.
  assign w_req     = reset_n && r_state == ST_FETCH && (run_en || r_pend);
  assign w_fire    = w_req && imem.imem_valid;
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign halted  = r_state == ST_HALT;
  assign acc_out = r_acc;
  assign pc_out  = r_pc;
  assign flag_z  = r_z;
  assign flag_c  = r_c;
  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op(w_op), .acc(r_acc), .opnd(w_opnd), .c_in(r_c),
    .result(w_res), .c_out(w_c), .z_out(w_z)
  );
`ifdef CPU_MUL_EN
  localparam int PW = DATA_W + OPND_W;
  localparam int CW = $clog2(OPND_W + 1);
  logic [PW-1:0]   r_prod, w_prod_nxt;
  logic [CW-1:0]   r_mcnt;
  logic [DATA_W:0] w_sum;
  logic            w_mul_done;
  // Right-shifting product register: multiplier starts in the low bits and is
  // consumed LSB first while partial sums accumulate in the high bits.
  assign w_sum      = {1'b0, r_prod[PW-1:OPND_W]} + (r_prod[0] ? {1'b0, r_acc} : '0);
  assign w_prod_nxt = {w_sum, r_prod[OPND_W-1:1]};
  assign w_mul_done = r_mcnt == CW'(OPND_W - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prod <= '0;
      r_mcnt <= '0;
    end else if (r_state == ST_EXEC) begin
      r_prod <= {{DATA_W{1'b0}}, r_ir[OPND_W-1:0]};
      r_mcnt <= '0;
    end else if (r_state == ST_MUL) begin
      r_prod <= w_prod_nxt;
      r_mcnt <= r_mcnt + CW'(1);
    end
  end
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_FETCH;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: w_next = w_fire ? ST_EXEC : ST_FETCH;
      ST_EXEC: begin
        w_next = w_op == OP_HLT ? ST_HALT : ST_FETCH;
`ifdef CPU_MUL_EN
        if (w_op == OP_MUL) w_next = ST_MUL;
`endif
      end
`ifdef CPU_MUL_EN
      ST_MUL: w_next = w_mul_done ? ST_FETCH : ST_MUL;
`endif
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc   <= '0;
      r_acc  <= '0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_ir   <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_req && !imem.imem_valid;
      if (w_fire) r_ir <= imem.imem_data;
      if (r_state == ST_EXEC) begin
`ifdef CPU_MUL_EN
        if (w_op != OP_MUL) r_pc <= w_pc_next;
`else
        r_pc <= w_pc_next;
`endif
        if (writes_acc(w_op)) begin
          r_acc <= w_res;
          r_c   <= w_c;
          r_z   <= w_z;
        end
      end
`ifdef CPU_MUL_EN
      if (r_state == ST_MUL && w_mul_done) begin
        r_acc <= w_prod_nxt[DATA_W-1:0];
        r_c   <= |w_prod_nxt[PW-1:DATA_W];
        r_z   <= w_prod_nxt[DATA_W-1:0] == '0;
        r_pc  <= w_pc_inc;
      end
`endif
    end
  end
endmodule
